// File: rtl/quad_7seg_scanner.sv
// Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
// Values enter through valid/ready and are committed only on frame boundaries.
module quad_7seg_scanner #(
    parameter int CLK_HZ           = 27000000,
    parameter int SLOT_HZ          = 4000,
    parameter int BLANK_CYCLES     = 270,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] valueIn,
    input  logic [3:0]  dpIn,
    input  logic        lzbEn,
    input  logic        loadValid,
    output logic        loadReady,
    output logic [3:0]  numDigit,
    output logic        dpOut,
    output logic        digitEnable,
    output logic [3:0]  anodeSel,
    output logic        frameTick
);
    localparam int SLOT_CYCLES = CLK_HZ / SLOT_HZ;
    localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_CNT  = CW'(BLANK_CYCLES);
    localparam logic [3:0]    ANODE_OFF = ANODE_ACTIVE_LOW ? 4'hF : 4'h0;

    typedef enum logic {BLANK, SHOW} phase_t;

    phase_t      phase;
    logic [CW-1:0] slotCnt;
    logic [1:0]  digitIdx;
    logic [15:0] dispVal;
    logic [3:0]  dispDp;
    logic [15:0] pendVal;
    logic [3:0]  pendDp;
    logic        pendFull;

    logic [CW-1:0] slotNext;
    logic        slotWrap;
    logic        frameWrap;
    logic        accept;
    logic        commit;
    logic        showNext;
    logic [3:0]  zeroFrom;
    logic [3:0]  blanked;
    logic [3:0]  digitOneHot;
    logic [3:0]  curNibble;
    logic        curDp;

    // Handshake: a transfer happens on an edge where loadValid && loadReady;
    // loadReady is high exactly while the single pending register is empty.
    assign loadReady = !pendFull;

    always_comb begin
        slotWrap  = (slotCnt == LAST_CNT);
        frameWrap = slotWrap && (digitIdx == 2'd3);
        slotNext  = slotWrap ? '0 : slotCnt + CW'(1);
        accept    = loadValid && !pendFull;
        commit    = frameWrap && pendFull;
        showNext  = ((phase == BLANK) && (slotNext == SHOW_CNT)) ||
                    ((phase == SHOW) && !slotWrap);
        // zeroFrom[k]: nibbles k..3 and decimal points k..3 are all zero
        zeroFrom[3] = (dispVal[15:12] == 4'h0) && !dispDp[3];
        for (int k = 2; k >= 0; k--) begin
            zeroFrom[k] = zeroFrom[k+1] && (dispVal[4*k +: 4] == 4'h0) && !dispDp[k];
        end
        blanked     = lzbEn ? {zeroFrom[3:1], 1'b0} : 4'b0000;
        curNibble   = dispVal[4*digitIdx +: 4];
        curDp       = dispDp[digitIdx];
        digitOneHot = 4'b0001 << digitIdx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase       <= BLANK;
            slotCnt     <= '0;
            digitIdx    <= 2'd0;
            dispVal     <= 16'h0000;
            dispDp      <= 4'h0;
            pendVal     <= 16'h0000;
            pendDp      <= 4'h0;
            pendFull    <= 1'b0;
            numDigit    <= 4'h0;
            dpOut       <= 1'b0;
            digitEnable <= 1'b0;
            anodeSel    <= ANODE_OFF;
            frameTick   <= 1'b0;
        end else begin
            slotCnt   <= slotNext;
            frameTick <= frameWrap;
            if (slotWrap) begin
                digitIdx <= digitIdx + 2'd1;
            end

            if (commit) begin
                dispVal  <= pendVal;
                dispDp   <= pendDp;
                pendFull <= 1'b0;
            end else if (accept) begin
                pendVal  <= valueIn;
                pendDp   <= dpIn;
                pendFull <= 1'b1;
            end

            // Outputs change on the same edge as the phase they belong to.
            if (showNext) begin
                phase       <= SHOW;
                numDigit    <= curNibble;
                dpOut       <= curDp;
                digitEnable <= !blanked[digitIdx];
                if (blanked[digitIdx]) begin
                    anodeSel <= ANODE_OFF;
                end else begin
                    anodeSel <= ANODE_ACTIVE_LOW ? ~digitOneHot : digitOneHot;
                end
            end else begin
                phase       <= BLANK;
                digitEnable <= 1'b0;
                anodeSel    <= ANODE_OFF;
            end
        end
    end
endmodule

// File: tb/tb_quad_7seg_scanner.sv
// Bench for quad_7seg_scanner: two instances (active-low and active-high anodes)
// share stimulus and are checked cycle by cycle against a time-based model.
module tb_quad_7seg_scanner;
    localparam int SLOT  = 10;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] valueIn = 16'h0;
    logic [3:0]  dpIn = 4'h0;
    logic        lzbEn = 1'b0;
    logic        loadValid = 1'b0;

    logic        loadReadyA, dpOutA, digitEnableA, frameTickA;
    logic [3:0]  numDigitA, anodeSelA;
    logic        loadReadyB, dpOutB, digitEnableB, frameTickB;
    logic [3:0]  numDigitB, anodeSelB;

    int checks = 0;
    int errors = 0;

    // expected word: {anodeLow[3:0], anodeHigh[3:0], numDigit[3:0], dp, en, tick, ready}
    logic [15:0] exp_q[$];

    // model state
    int          mT;
    logic [15:0] mDispVal, mPendVal;
    logic [3:0]  mDispDp, mPendDp, mLastNum;
    logic        mPendFull, mLastDp;

    quad_7seg_scanner #(
        .CLK_HZ(1000), .SLOT_HZ(100), .BLANK_CYCLES(BLANK), .ANODE_ACTIVE_LOW(1'b1)
    ) dutA (
        .clk(clk), .rst(rst), .valueIn(valueIn), .dpIn(dpIn), .lzbEn(lzbEn),
        .loadValid(loadValid), .loadReady(loadReadyA), .numDigit(numDigitA),
        .dpOut(dpOutA), .digitEnable(digitEnableA), .anodeSel(anodeSelA),
        .frameTick(frameTickA)
    );

    quad_7seg_scanner #(
        .CLK_HZ(1000), .SLOT_HZ(100), .BLANK_CYCLES(BLANK), .ANODE_ACTIVE_LOW(1'b0)
    ) dutB (
        .clk(clk), .rst(rst), .valueIn(valueIn), .dpIn(dpIn), .lzbEn(lzbEn),
        .loadValid(loadValid), .loadReady(loadReadyB), .numDigit(numDigitB),
        .dpOut(dpOutB), .digitEnable(digitEnableB), .anodeSel(anodeSelB),
        .frameTick(frameTickB)
    );

    // clock / reset
    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: outputs follow from the cycle count since reset.
    initial begin : model
        int   pos, dig;
        logic frame, acc, com, on;
        logic [3:0] anLo, anHi;
        mT = 0; mPendFull = 1'b0; mDispVal = '0; mDispDp = '0;
        mPendVal = '0; mPendDp = '0; mLastNum = '0; mLastDp = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mT = 0; mPendFull = 1'b0; mDispVal = '0; mDispDp = '0;
                mLastNum = '0; mLastDp = 1'b0;
                exp_q.delete();
            end else begin
                mT++;
                frame = (mT % FRAME == 0);
                acc = loadValid && !mPendFull;
                com = frame && mPendFull;
                if (com) begin
                    mDispVal = mPendVal; mDispDp = mPendDp; mPendFull = 1'b0;
                end
                if (acc) begin
                    mPendVal = valueIn; mPendDp = dpIn; mPendFull = 1'b1;
                end
                pos = mT % SLOT;
                dig = (mT / SLOT) % 4;
                on = 1'b0;
                if (pos >= BLANK) begin
                    mLastNum = mDispVal[4*dig +: 4];
                    mLastDp  = mDispDp[dig];
                    on = !(lzbEn && dig != 0 && (mDispVal >> (4*dig)) == 16'h0 &&
                           (mDispDp >> dig) == 4'h0);
                end
                anLo = on ? ~(4'b0001 << dig) : 4'hF;
                anHi = on ?  (4'b0001 << dig) : 4'h0;
                exp_q.push_back({anLo, anHi, mLastNum, mLastDp, on, frame, !mPendFull});
            end
        end
    end

    // Monitor / scoreboard: one expected word per cycle, compared on the falling edge.
    initial begin : monitor
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_A", {anodeSelA, 4'h0, numDigitA, dpOutA, digitEnableA, frameTickA, loadReadyA},
                    16'hF001);
                chk("reset_B", {anodeSelB, 4'h0, numDigitB, dpOutB, digitEnableB, frameTickB, loadReadyB},
                    16'h0001);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("outputs_A{an,0,num,dp,en,tick,rdy}",
                    {anodeSelA, 4'h0, numDigitA, dpOutA, digitEnableA, frameTickA, loadReadyA},
                    {e[15:12], 4'h0, e[7:0]});
                chk("outputs_B{an,0,num,dp,en,tick,rdy}",
                    {anodeSelB, 4'h0, numDigitB, dpOutB, digitEnableB, frameTickB, loadReadyB},
                    {e[11:8], 4'h0, e[7:0]});
            end
        end
    end

    // driver tasks: inputs change 1 time unit after the falling edge
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic waitPhase(input int m);
        int n = 0;
        while ((mT % FRAME) != m && n < 200) begin
            step();
            n++;
        end
        checks++;
        if ((mT % FRAME) != m) begin
            errors++;
            $display("FAIL wait_phase: frame position %0d required %0d", mT % FRAME, m);
        end
    endtask

    task automatic doLoad(input logic [15:0] v, input logic [3:0] d);
        int n = 0;
        while (mPendFull && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (mPendFull) begin
            errors++;
            $display("FAIL load_wait: pending still full after %0d cycles, required empty", n);
        end
        loadValid = 1'b1; valueIn = v; dpIn = d;
        step();
        loadValid = 1'b0;
    endtask

    function automatic logic [15:0] randVal();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) begin
            v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    initial begin : stimulus
        repeat (3) step();
        rst = 1'b0;

        // idle scan of zero
        repeat (45) step();

        // single mid-frame load
        waitPhase(13);
        doLoad(16'h1234, 4'b0010);
        repeat (90) step();

        // valid held high with a new value every cycle
        repeat (200) begin
            loadValid = 1'b1;
            valueIn = 16'($urandom);
            dpIn = 4'($urandom);
            step();
        end
        loadValid = 1'b0;
        repeat (45) step();

        // leading-zero blanking
        lzbEn = 1'b1;
        doLoad(16'h0050, 4'b0000);
        repeat (85) step();
        doLoad(16'h0000, 4'b0000);
        repeat (85) step();
        doLoad(16'h0000, 4'b1000);
        repeat (85) step();
        lzbEn = 1'b0;

        // asynchronous reset during digit 2's show phase with a load pending
        waitPhase(2);
        doLoad(16'hABCD, 4'hF);
        waitPhase(24);
        chk("pre_reset_anode_A", {12'h0, anodeSelA}, 16'h000B);
        #2;
        rst = 1'b1;
        #1;
        chk("async_anode_A", {12'h0, anodeSelA}, 16'h000F);
        chk("async_anode_B", {12'h0, anodeSelB}, 16'h0000);
        chk("async_ready_A", {15'h0, loadReadyA}, 16'h0001);
        chk("async_enable_A", {15'h0, digitEnableA}, 16'h0000);
        step();
        step();
        rst = 1'b0;
        repeat (50) step();

        // randomized traffic
        for (int c = 0; c < 700; c++) begin
            if (c % 50 == 0) lzbEn = 1'($urandom_range(0, 1));
            loadValid = ($urandom_range(0, 3) == 0);
            valueIn = randVal();
            dpIn = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            step();
        end
        loadValid = 1'b0;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
